// File: rtl/branch_resolve_unit.sv
`timescale 1ns/1ps
// branch_resolve_unit: EX-stage branch/jump resolution, mispredict redirect,
// 2-bit saturating-counter BHT for IF prediction, and perf counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int INDEX_LSB = 2,
  parameter int REG_OUT   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             stall,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic             out_valid,
  output logic             out_taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_JAL  = 3'b010;
  localparam logic [2:0] OP_NONE = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  logic [1:0]      bht [BHT_DEPTH];
  logic [IW-1:0]   ex_idx;
  logic [IW-1:0]   if_idx;
  logic            squash;
  logic            is_br;
  logic            taken;
  logic            mis;
  logic            bht_upd;
  logic [XLEN-1:0] redir;
  logic            unused_if_pc;

  assign ex_idx        = ex_pc[INDEX_LSB +: IW];
  assign if_idx        = if_pc[INDEX_LSB +: IW];
  assign if_pred_taken = bht[if_idx][1];
  assign unused_if_pc  = ^if_pc;

  // Branch condition evaluation over the full operand width.
  always_comb begin
    taken = 1'b0;
    case (ex_op)
      OP_BEQ:  taken = (data1 == data2);
      OP_BNE:  taken = (data1 != data2);
      OP_JAL:  taken = 1'b1;
      OP_BLT:  taken = ($signed(data1) <  $signed(data2));
      OP_BGE:  taken = ($signed(data1) >= $signed(data2));
      OP_BLTU: taken = (data1 <  data2);
      OP_BGEU: taken = (data1 >= data2);
      default: taken = 1'b0;
    endcase
  end

  // Qualification, mispredict detect and redirect target (pc+4 wraps naturally).
  always_comb begin
    is_br   = RESET_N & ex_valid & ~stall & ~squash & (ex_op != OP_NONE);
    mis     = is_br & (taken != ex_pred_taken);
    bht_upd = is_br & (ex_op != OP_JAL);
    redir   = taken ? ex_target : (ex_pc + XLEN'(4));
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      // Resolution registers; direction/target only refresh on a real branch.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          out_valid   <= 1'b0;
          out_taken   <= 1'b0;
          mispredict  <= 1'b0;
          redirect_pc <= '0;
        end else if (!stall) begin
          out_valid  <= is_br;
          mispredict <= mis;
          if (is_br) begin
            out_taken   <= taken;
            redirect_pc <= redir;
          end
        end
      end
      // The instruction sitting in EX while a registered flush is presented is wrong-path.
      assign squash = mispredict;
    end else begin : g_comb
      // Same-cycle resolution; the pipeline flushes EX itself so nothing is squashed here.
      assign out_valid   = is_br;
      assign out_taken   = taken;
      assign mispredict  = mis;
      assign redirect_pc = redir;
      assign squash      = 1'b0;
    end
  endgenerate

  // BHT counters: reset to weakly not-taken, saturating train on conditional branches.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (bht_upd) begin
      if (taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (is_br && (branch_count != '1))
        branch_count <= branch_count + CNT_W'(1);
      if (mis && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
`timescale 1ns/1ps
module tb_branch_resolve_unit;

  logic        CLK;
  logic        RESET_N;
  logic        ex_valid;
  logic        ex_valid4;
  logic [2:0]  ex_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        stall;
  logic [31:0] if_pc;

  logic        if_pred_taken;
  logic        out_valid;
  logic        out_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic        if_pred_taken4;
  logic        out_valid4;
  logic        out_taken4;
  logic        mispredict4;
  logic [31:0] redirect_pc4;
  logic [3:0]  branch_count4;
  logic [3:0]  mispredict_count4;

  int vectors = 0;
  int errs    = 0;

  branch_resolve_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .ex_valid(ex_valid), .ex_op(ex_op),
    .data1(data1), .data2(data2), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .stall(stall), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .out_valid(out_valid), .out_taken(out_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.REG_OUT(0), .CNT_W(4)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .ex_valid(ex_valid4), .ex_op(ex_op),
    .data1(data1), .data2(data2), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .stall(stall), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken4), .out_valid(out_valid4), .out_taken(out_taken4),
    .mispredict(mispredict4), .redirect_pc(redirect_pc4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred);
    ex_valid      = v;
    ex_op         = op;
    data1         = a;
    data2         = b;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
  endtask

  initial begin
    RESET_N   = 1'b0;
    stall     = 1'b0;
    if_pc     = 32'h0;
    ex_valid4 = 1'b0;
    drive(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_taken", 32'(out_taken), 32'h0);
    chk("rst_mispredict", 32'(mispredict), 32'h0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_branch_count", branch_count, 32'h0);
    chk("rst_mispredict_count", mispredict_count, 32'h0);
    #20;
    RESET_N = 1'b1;

    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      chk("bht_init", 32'(if_pred_taken), 32'h0);
    end

    // BLT signed: -1 < 1 taken, predicted not-taken
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h80, 1'b0);
    tick;
    chk("blt_valid", 32'(out_valid), 32'h1);
    chk("blt_taken", 32'(out_taken), 32'h1);
    chk("blt_mis", 32'(mispredict), 32'h1);
    chk("blt_redirect", redirect_pc, 32'h80);
    chk("blt_mis_count", mispredict_count, 32'h1);
    chk("blt_br_count", branch_count, 32'h1);

    // wrong-path BNE (taken) must be squashed
    drive(1'b1, 3'b001, 32'h3, 32'h4, 32'h204, 32'h500, 1'b1);
    tick;
    chk("sq_valid", 32'(out_valid), 32'h0);
    chk("sq_mis", 32'(mispredict), 32'h0);
    chk("sq_br_count", branch_count, 32'h1);
    chk("sq_taken_hold", 32'(out_taken), 32'h1);
    chk("sq_redirect_hold", redirect_pc, 32'h80);
    if_pc = 32'h204;
    #1;
    chk("sq_bht_unchanged", 32'(if_pred_taken), 32'h0);
    if_pc = 32'h100;
    #1;
    chk("blt_bht_trained", 32'(if_pred_taken), 32'h1);

    // BLTU unsigned: 0xFFFFFFFF < 1 false
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h80, 1'b0);
    tick;
    chk("bltu_valid", 32'(out_valid), 32'h1);
    chk("bltu_taken", 32'(out_taken), 32'h0);
    chk("bltu_mis", 32'(mispredict), 32'h0);
    chk("bltu_redirect", redirect_pc, 32'h104);
    chk("bltu_br_count", branch_count, 32'h2);
    chk("bltu_mis_count", mispredict_count, 32'h1);
    #1;
    chk("bltu_bht", 32'(if_pred_taken), 32'h0);

    // BEQ taken three times at 0x40 (entry 16): 01->10->11->11
    if_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h40, 32'h300, 1'b1);
      tick;
      chk("beq_t_pred", 32'(if_pred_taken), 32'h1);
      chk("beq_t_br_count", branch_count, 32'(3 + k));
    end
    chk("beq_t_taken", 32'(out_taken), 32'h1);
    chk("beq_t_mis", 32'(mispredict), 32'h0);

    // two not-taken: 11->10->01
    drive(1'b1, 3'b000, 32'h5, 32'h6, 32'h40, 32'h300, 1'b0);
    tick;
    chk("beq_nt1_pred", 32'(if_pred_taken), 32'h1);
    tick;
    chk("beq_nt2_pred", 32'(if_pred_taken), 32'h0);
    chk("beq_nt_taken", 32'(out_taken), 32'h0);
    chk("beq_nt_br_count", branch_count, 32'h7);
    chk("beq_nt_mis_count", mispredict_count, 32'h1);

    // JAL predicted taken: no mispredict, BHT untouched
    drive(1'b1, 3'b010, 32'h0, 32'h0, 32'h40, 32'h300, 1'b1);
    tick;
    chk("jal_valid", 32'(out_valid), 32'h1);
    chk("jal_taken", 32'(out_taken), 32'h1);
    chk("jal_mis", 32'(mispredict), 32'h0);
    chk("jal_redirect", redirect_pc, 32'h300);
    chk("jal_br_count", branch_count, 32'h8);
    chk("jal_mis_count", mispredict_count, 32'h1);
    chk("jal_bht", 32'(if_pred_taken), 32'h0);

    // pc+4 wraps at top of address space
    drive(1'b1, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h10, 1'b1);
    tick;
    chk("wrap_valid", 32'(out_valid), 32'h1);
    chk("wrap_taken", 32'(out_taken), 32'h0);
    chk("wrap_mis", 32'(mispredict), 32'h1);
    chk("wrap_redirect", redirect_pc, 32'h0);
    chk("wrap_br_count", branch_count, 32'h9);
    chk("wrap_mis_count", mispredict_count, 32'h2);

    drive(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick;
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_mis", 32'(mispredict), 32'h0);

    // stall with a mispredicting taken BEQ: nothing may change
    stall = 1'b1;
    drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h40, 32'h300, 1'b0);
    tick;
    chk("stall_valid", 32'(out_valid), 32'h0);
    chk("stall_mis", 32'(mispredict), 32'h0);
    chk("stall_taken", 32'(out_taken), 32'h0);
    chk("stall_redirect", redirect_pc, 32'h0);
    chk("stall_br_count", branch_count, 32'h9);
    chk("stall_mis_count", mispredict_count, 32'h2);
    chk("stall_bht", 32'(if_pred_taken), 32'h0);
    stall = 1'b0;
    drive(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick;

    // combinational build with 4-bit counters
    drive(1'b0, 3'b000, 32'h5, 32'h5, 32'h40, 32'h300, 1'b1);
    ex_valid4 = 1'b1;
    #1;
    chk("c_valid", 32'(out_valid4), 32'h1);
    chk("c_taken", 32'(out_taken4), 32'h1);
    chk("c_mis", 32'(mispredict4), 32'h0);
    chk("c_redirect", redirect_pc4, 32'h300);
    ex_pred_taken = 1'b0;
    #1;
    chk("c_mis_on", 32'(mispredict4), 32'h1);
    ex_pred_taken = 1'b1;
    repeat (15) tick;
    chk("c_br_count15", 32'(branch_count4), 32'hF);
    tick;
    chk("c_br_count_sat", 32'(branch_count4), 32'hF);
    chk("c_mis_count", 32'(mispredict_count4), 32'h0);
    chk("main_idle_count", branch_count, 32'h9);
    ex_valid4 = 1'b0;

    // async reset mid-stream
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h80, 1'b0);
    if_pc = 32'h100;
    tick;
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_mis", 32'(mispredict), 32'h1);
    chk("pre_rst_br_count", branch_count, 32'hA);
    chk("pre_rst_bht", 32'(if_pred_taken), 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_taken", 32'(out_taken), 32'h0);
    chk("mid_rst_mis", 32'(mispredict), 32'h0);
    chk("mid_rst_redirect", redirect_pc, 32'h0);
    chk("mid_rst_br_count", branch_count, 32'h0);
    chk("mid_rst_mis_count", mispredict_count, 32'h0);
    chk("mid_rst_bht", 32'(if_pred_taken), 32'h0);
    chk("mid_rst_c_count", 32'(branch_count4), 32'h0);
    drive(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #10;
    RESET_N = 1'b1;
    tick;
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
